// File: rtl/rx_fifo_if.sv
// -----------------------------------------------------------------------------
// rx_fifo_if
// Bundles the producer/consumer signals of the receive FIFO.
//   master : the surrounding logic (receiver control unit plus consumer);
//            drives load_buffer, packet_data and data_read, and observes status.
//   slave  : the FIFO itself.
// Signals:
//   load_buffer   - one-cycle write strobe
//   packet_data   - byte to store, valid with load_buffer
//   data_read     - pop strobe, one pop per cycle it is high
//   rx_data       - head entry (show-ahead), zero when empty
//   data_ready    - FIFO holds at least one byte
//   overrun_error - sticky: a byte was dropped because the FIFO was full
//   fifo_count    - occupancy, 0..DEPTH
//   almost_full   - only when RX_FIFO_ALMOST_FULL_EN is defined
// -----------------------------------------------------------------------------
interface rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic                  load_buffer;
    logic [DATA_WIDTH-1:0] packet_data;
    logic                  data_read;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  data_ready;
    logic                  overrun_error;
    logic [ADDR_BITS:0]    fifo_count;
`ifdef RX_FIFO_ALMOST_FULL_EN
    logic                  almost_full;

    modport master (
        output load_buffer, packet_data, data_read,
        input  rx_data, data_ready, overrun_error, fifo_count, almost_full
    );

    modport slave (
        input  load_buffer, packet_data, data_read,
        output rx_data, data_ready, overrun_error, fifo_count, almost_full
    );
`else
    modport master (
        output load_buffer, packet_data, data_read,
        input  rx_data, data_ready, overrun_error, fifo_count
    );

    modport slave (
        input  load_buffer, packet_data, data_read,
        output rx_data, data_ready, overrun_error, fifo_count
    );
`endif
endinterface

// File: rtl/rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
// Receive-side byte buffer sitting directly behind the UART receiver control
// unit. Bytes captured on load_buffer are presented in arrival order with
// show-ahead read data; occupancy and a sticky overrun flag are exported.
//
// Ports:
//   clk - system clock, all state changes on the rising edge
//   rst - asynchronous, active-high reset; discards all entries immediately
//   bus - rx_fifo_if.slave (load_buffer, packet_data, data_read, rx_data,
//         data_ready, overrun_error, fifo_count[, almost_full])
//
// Optional feature: define RX_FIFO_ALMOST_FULL_EN to add parameter AF_THRESH
// and the registered almost_full output.
// -----------------------------------------------------------------------------
module rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH  = DEPTH - 1
`endif
) (
    input  logic        clk,
    input  logic        rst,
    rx_fifo_if.slave    bus
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int CW        = ADDR_BITS + 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_r;
    logic [ADDR_BITS-1:0]  rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  overrun_r;
    logic                  rd_en_s;
    logic                  wr_en_s;
    logic                  overrun_set_s;
    logic [DATA_WIDTH-1:0] head_s;

    // Accept/reject decisions. A push into a full FIFO still succeeds when the
    // same cycle frees a slot; a pop on an empty FIFO is silently ignored.
    always_comb begin
        rd_en_s       = bus.data_read && (count_r != CW'(0));
        wr_en_s       = bus.load_buffer && ((count_r != CW'(DEPTH)) || rd_en_s);
        overrun_set_s = bus.load_buffer && !wr_en_s;
    end

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        case ({wr_en_s, rd_en_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= bus.packet_data;
        end
    end

    // Pointers, occupancy and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= ADDR_BITS'(0);
            rd_ptr_r  <= ADDR_BITS'(0);
            count_r   <= CW'(0);
            overrun_r <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_BITS'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_BITS'(1);
            end
            count_r <= count_next_s;
            // A fresh drop outranks the clear from an accepted pop.
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (rd_en_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Show-ahead head entry, forced to zero while empty.
    always_comb begin
        if (count_r != CW'(0)) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign bus.rx_data       = head_s;
    assign bus.data_ready    = (count_r != CW'(0));
    assign bus.overrun_error = overrun_r;
    assign bus.fifo_count    = count_r;

`ifdef RX_FIFO_ALMOST_FULL_EN
    logic almost_full_r;

    // Tracks the next-state count so it moves on the same edge as fifo_count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_r <= 1'b0;
        end else begin
            almost_full_r <= (count_next_s >= CW'(AF_THRESH));
        end
    end

    assign bus.almost_full = almost_full_r;
`endif
endmodule
